// File: rtl/ws2812_frame_buf_if.sv
// Pixel write / commit bus and downstream pixel stream of the WS2812 frame buffer.
// master: host plus serializer side; slave: the frame buffer.
interface ws2812_frame_buf_if #(
    parameter int unsigned NumLeds = 8
);
    localparam int unsigned IdxW = (NumLeds > 1) ? $clog2(NumLeds) : 1;
    localparam int unsigned PixW = 24;
    localparam int unsigned BriW = 8;

    logic            wr_en;
    logic [IdxW-1:0] wr_addr;
    logic [PixW-1:0] wr_rgb;
    logic            commit;
    logic [BriW-1:0] brightness;
    logic            px_valid;
    logic            px_ready;
    logic [PixW-1:0] px_color;
    logic            px_last;
    logic            busy;
    logic            frame_done;

    modport master (
        output wr_en, wr_addr, wr_rgb, commit, brightness, px_ready,
        input  px_valid, px_color, px_last, busy, frame_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_rgb, commit, brightness, px_ready,
        output px_valid, px_color, px_last, busy, frame_done
    );
endinterface

// File: rtl/ws2812_frame_buf.sv
// Double-buffered WS2812 frame store: host writes a shadow buffer, commit snapshots
// it into the active buffer, which is streamed out brightness-scaled in GRB order.
module ws2812_frame_buf #(
    parameter int unsigned NumLeds   = 8,
    parameter int unsigned GapCycles = 32'd3500
) (
    input  logic              clk,
    input  logic              rst_n,
    ws2812_frame_buf_if.slave bus
);
    localparam int unsigned IdxW = (NumLeds > 1) ? $clog2(NumLeds) : 1;
    localparam int unsigned PixW = 24;
    localparam int unsigned BriW = 8;
    localparam int unsigned CntW = 32;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumLeds - 1);
    localparam logic [CntW-1:0] GapLast = CntW'(GapCycles - 1);

    typedef enum logic [1:0] {Idle, Load, Stream, Gap} state_t;

    state_t          state;
    logic            pending;
    logic [IdxW-1:0] idx;
    logic [CntW-1:0] gap_cnt;
    logic [BriW-1:0] bri_q;
    logic [PixW-1:0] shadow [NumLeds];
    logic [PixW-1:0] active [NumLeds];
    logic [IdxW-1:0] idx_nxt_c;

    assign idx_nxt_c = idx + IdxW'(1);

    // (c * (bri + 1)) >> 8 keeps bri = 255 exact and bri = 0 fully dark
    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [BriW-1:0] bri);
        return 8'((16'(c) * (16'(bri) + 16'd1)) >> 8);
    endfunction

    function automatic logic [PixW-1:0] scale_px(input logic [PixW-1:0] rgb,
                                                 input logic [BriW-1:0] bri);
        return {scale_ch(rgb[15:8], bri), scale_ch(rgb[23:16], bri), scale_ch(rgb[7:0], bri)};
    endfunction

    // Host-side shadow buffer; out-of-range addresses are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NumLeds); i++) shadow[i] <= '0;
        end else if (bus.wr_en && (CntW'(bus.wr_addr) < NumLeds)) begin
            shadow[bus.wr_addr] <= bus.wr_rgb;
        end
    end

    // Frame sequencer: snapshot, stream with backpressure, then enforce the latch gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= Idle;
            pending        <= 1'b0;
            idx            <= '0;
            gap_cnt        <= '0;
            bri_q          <= '0;
            bus.px_valid   <= 1'b0;
            bus.px_color   <= '0;
            bus.px_last    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
            for (int i = 0; i < int'(NumLeds); i++) active[i] <= '0;
        end else begin
            bus.frame_done <= 1'b0;
            pending        <= pending | bus.commit;
            case (state)
                Idle: begin
                    if (pending) begin
                        // a commit landing on this edge re-arms for the following frame
                        pending  <= bus.commit;
                        bri_q    <= bus.brightness;
                        bus.busy <= 1'b1;
                        state    <= Load;
                        for (int i = 0; i < int'(NumLeds); i++) active[i] <= shadow[i];
                    end
                end
                Load: begin
                    idx          <= '0;
                    bus.px_color <= scale_px(active[0], bri_q);
                    bus.px_valid <= 1'b1;
                    bus.px_last  <= (NumLeds == 1);
                    state        <= Stream;
                end
                Stream: begin
                    if (bus.px_ready) begin
                        if (idx == LastIdx) begin
                            bus.px_valid   <= 1'b0;
                            bus.px_last    <= 1'b0;
                            bus.frame_done <= 1'b1;
                            gap_cnt        <= '0;
                            state          <= Gap;
                        end else begin
                            idx          <= idx_nxt_c;
                            bus.px_color <= scale_px(active[idx_nxt_c], bri_q);
                            bus.px_last  <= (idx_nxt_c == LastIdx);
                        end
                    end
                end
                Gap: begin
                    if (gap_cnt == GapLast) begin
                        bus.busy <= 1'b0;
                        state    <= Idle;
                    end else begin
                        gap_cnt <= gap_cnt + CntW'(1);
                    end
                end
                default: state <= Idle;
            endcase
        end
    end
endmodule
